step_scheduler: RTL and testbench
=================================

Name: step_scheduler

Overview:
Game-flow controller for the dance game. It sequences the random arrow generator by issuing one `change_tick` per beat and latches the three lane arrows that the generator returns. It judges player presses against those arrows inside a timing window and keeps score, combo and lives. It sits between the arrow generator, the button debouncers and the display/score logic.

Parameters:
BEAT_TICKS, 25000000, clk cycles per beat; must be greater than WINDOW_TICKS+2
WINDOW_TICKS, 5000000, hit-window length in clk cycles
SONG_BEATS, 64, arrows per song (1..255)
LIVES, 3, starting lives (1..3)
COUNTDOWN_BEATS, 4, beats of countdown before the first arrow (1..255)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse that starts a game
n1, n2, n3  in  3 each  lane arrows from the generator; 0..3 = direction, 4 = no arrow
press  in  3  one-cycle press pulse per lane; bit0 = lane1
dir1, dir2, dir3  in  2 each  direction held by the player on each lane, sampled with press
change_tick  out  1  one-cycle strobe that drives the generator's change input
target1, target2, target3  out  3 each  latched lane arrows
score  out  16  saturating score
combo  out  8  saturating combo count
lives  out  2  remaining lives
beat_cnt  out  8  beats elapsed in the current phase
state  out  2  0 = IDLE, 1 = COUNT, 2 = PLAY, 3 = OVER
game_over  out  1  high exactly when state = OVER

Behaviour:
- Reset state: state = IDLE; all counters 0; score, combo, lives, change_tick = 0; target1..3 = 4; pending[2:0] = 0.
- The block uses one clock and an asynchronous active-low reset. Asserting rst_n mid-game returns every output to its reset value immediately.
- tick_cnt runs from 0 to BEAT_TICKS-1 and wraps to 0. It counts only in COUNT and PLAY and is held at 0 in IDLE and OVER.
- IDLE or OVER, on start: go to COUNT. Set tick_cnt = 0, beat_cnt = 0, score = 0, combo = 0, lives = LIVES, targets = 4.
- start is ignored in COUNT and PLAY.
- COUNT: beat_cnt increments on each wrap of tick_cnt.
  - On a wrap with beat_cnt = COUNTDOWN_BEATS-1: go to PLAY with tick_cnt = 0 and beat_cnt = 0.
- PLAY: change_tick is a registered output, high for the single cycle in which tick_cnt = 0. beat_cnt increments in that same cycle.
- Target latch: on the edge that ends the tick_cnt = 1 cycle, target_i <= n_i. Also set pending_i = (n_i != 4).
- Hit window: open while 2 <= tick_cnt < WINDOW_TICKS+2.
- Hit: press_i while the window is open, pending_i is set and dir_i == target_i[1:0].
  - Effect: score += 10 + combo (combo value before this cycle; saturate at 16'hFFFF), combo +1 (saturate at 255), pending_i cleared.
- Miss, wrong direction: press_i while the window is open, pending_i is set and dir_i differs from the target.
- Miss, timeout: pending_i still set when tick_cnt = WINDOW_TICKS+2.
- Miss effect: combo = 0, lives -1 (saturate at 0), pending_i cleared.
- The following cause no action: press with no pending arrow, press outside the window, and any lane whose target = 4.
- Several lanes in one cycle:
  - Each hit adds 10 + old combo to score.
  - If any lane misses, combo = 0 regardless of hits; otherwise combo += number of hits.
  - lives decreases by the number of misses, saturating at 0.
- PLAY -> OVER on the first of these:
  - lives = 0: transition on the clock edge after lives reaches 0; no further judging that cycle.
  - tick_cnt = BEAT_TICKS-1 with beat_cnt = SONG_BEATS.
- OVER: change_tick = 0 and pending = 0; score, combo and lives hold their values.
- No overlap between beats: the window always closes before the next latch, because WINDOW_TICKS+2 < BEAT_TICKS.

Test Plan:
All scenarios use BEAT_TICKS=16, WINDOW_TICKS=6, SONG_BEATS=4, LIVES=3, COUNTDOWN_BEATS=2.
1. Reset, then 100 idle cycles -> state = 0, target1..3 = 4, change_tick never asserted, game_over = 0.
2. start pulse -> state = 1 for 32 cycles, then state = 2. change_tick pulses on the first PLAY cycle and every 16 cycles after; lives = 3.
3. Generator gives n1 = 2; press[0] with dir1 = 2 at tick 4 -> score = 10, combo = 1. Same on the next beat -> score = 21, combo = 2.
4. Wrong direction (dir1 = 1 against target 2) -> combo = 0, lives = 2. An arrow left unpressed -> lives drops by 1 at tick 8; a lane with target = 4 never costs a life.
5. Three misses -> lives = 0, then state = 3 and game_over = 1 on the next cycle, with no further change_tick. start -> state = 1, score = 0, lives = 3.
6. Four beats, all hit -> state = 3 after 4 full beat periods with score = 10+11+12+13 = 46. A rst_n low pulse mid-PLAY -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/step_scheduler.sv
// step_scheduler: game-flow controller for the dance game.
//   Issues one change_tick per beat to the arrow generator, latches the three
//   lane arrows it returns, judges presses inside a hit window and keeps
//   score / combo / lives.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 one-cycle game start pulse (honoured in IDLE/OVER)
//   n1..n3                generator arrows (0..3 direction, 4 = none)
//   press[2:0], dir1..3   per-lane press pulse and held direction
//   change_tick           registered strobe, high while tick_cnt = 0 in PLAY
//   target1..3            latched lane arrows
//   score/combo/lives     saturating game counters
//   beat_cnt, state       beats in current phase, 0 IDLE 1 COUNT 2 PLAY 3 OVER
//   game_over             state == OVER

// Per-lane target/pending tracking and hit/miss classification.
module step_scheduler_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,  // new game: clear target to "no arrow"
  input  logic       clr_i,    // drop pending without touching target
  input  logic       latch_i,  // capture generator arrow
  input  logic       win_i,    // hit window open (already gated by PLAY)
  input  logic       tmo_i,    // window just closed
  input  logic       press_i,
  input  logic [1:0] dir_i,
  input  logic [2:0] n_i,
  output logic [2:0] tgt_o,
  output logic       hit_o,
  output logic       miss_o
);
  logic [2:0] tgt_q, tgt_d;
  logic       pend_q, pend_d;

  always_comb begin
    hit_o  = pend_q && win_i && press_i && (dir_i == tgt_q[1:0]);
    miss_o = pend_q && ((win_i && press_i && (dir_i != tgt_q[1:0])) || tmo_i);
    tgt_d  = tgt_q;
    pend_d = pend_q;
    if (start_i) begin
      tgt_d  = 3'd4;
      pend_d = 1'b0;
    end else if (clr_i) begin
      pend_d = 1'b0;
    end else if (latch_i) begin
      tgt_d  = n_i;
      pend_d = (n_i != 3'd4);
    end else if (hit_o || miss_o) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_q  <= 3'd4;
      pend_q <= 1'b0;
    end else begin
      tgt_q  <= tgt_d;
      pend_q <= pend_d;
    end
  end

  assign tgt_o = tgt_q;
endmodule

module step_scheduler #(
  parameter int BEAT_TICKS      = 25000000,
  parameter int WINDOW_TICKS    = 5000000,
  parameter int SONG_BEATS      = 64,
  parameter int LIVES           = 3,
  parameter int COUNTDOWN_BEATS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  n1,
  input  logic [2:0]  n2,
  input  logic [2:0]  n3,
  input  logic [2:0]  press,
  input  logic [1:0]  dir1,
  input  logic [1:0]  dir2,
  input  logic [1:0]  dir3,
  output logic        change_tick,
  output logic [2:0]  target1,
  output logic [2:0]  target2,
  output logic [2:0]  target3,
  output logic [15:0] score,
  output logic [7:0]  combo,
  output logic [1:0]  lives,
  output logic [7:0]  beat_cnt,
  output logic [1:0]  state,
  output logic        game_over
);
  localparam int NUM_LANES = 3;
  localparam int TW        = $clog2(BEAT_TICKS);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_COUNT = 2'd1, S_PLAY = 2'd2, S_OVER = 2'd3} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [7:0]    beat_q, beat_d;
  logic [15:0]   score_q, score_d;
  logic [7:0]    combo_q, combo_d;
  logic [1:0]    lives_q, lives_d;
  logic          change_tick_q, change_tick_d;

  logic [NUM_LANES-1:0][2:0] n_all, tgt_all;
  logic [NUM_LANES-1:0][1:0] dir_all;
  logic [NUM_LANES-1:0]      hit, miss;

  logic play_act, tick_wrap, song_end, lane_start, lane_clr;
  logic latch, win, tmo;
  logic [1:0]  hit_cnt, miss_cnt;
  logic [17:0] score_sum;
  logic [8:0]  combo_sum;

  assign n_all   = {n3, n2, n1};
  assign dir_all = {dir3, dir2, dir1};

  // Judging is suppressed in the cycle where lives has already hit 0.
  assign play_act   = (state_q == S_PLAY) && (lives_q != 2'd0);
  assign tick_wrap  = (int'(tick_q) == BEAT_TICKS - 1);
  assign song_end   = tick_wrap && (int'(beat_q) == SONG_BEATS);
  assign latch      = play_act && (int'(tick_q) == 1);
  assign win        = play_act && (int'(tick_q) >= 2) && (int'(tick_q) < WINDOW_TICKS + 2);
  assign tmo        = play_act && (int'(tick_q) == WINDOW_TICKS + 2);
  assign lane_start = ((state_q == S_IDLE) || (state_q == S_OVER)) && start;
  assign lane_clr   = (state_q == S_PLAY) && ((lives_q == 2'd0) || song_end);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    step_scheduler_lane u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (lane_start),
      .clr_i   (lane_clr),
      .latch_i (latch),
      .win_i   (win),
      .tmo_i   (tmo),
      .press_i (press[i]),
      .dir_i   (dir_all[i]),
      .n_i     (n_all[i]),
      .tgt_o   (tgt_all[i]),
      .hit_o   (hit[i]),
      .miss_o  (miss[i])
    );
  end

  always_comb begin
    hit_cnt  = 2'd0;
    miss_cnt = 2'd0;
    for (int i = 0; i < NUM_LANES; i++) begin
      hit_cnt  = hit_cnt + 2'(hit[i]);
      miss_cnt = miss_cnt + 2'(miss[i]);
    end
    // Every hit in a cycle earns 10 + the combo from before that cycle.
    score_sum = {2'b00, score_q} + 18'(hit_cnt) * (18'd10 + 18'(combo_q));
    combo_sum = 9'(combo_q) + 9'(hit_cnt);
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    beat_d  = beat_q;
    score_d = score_q;
    combo_d = combo_q;
    lives_d = lives_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        tick_d = '0;
        if (start) begin
          state_d = S_COUNT;
          beat_d  = 8'd0;
          score_d = 16'd0;
          combo_d = 8'd0;
          lives_d = 2'(LIVES);
        end
      end
      S_COUNT: begin
        tick_d = tick_wrap ? '0 : tick_q + TW'(1);
        if (tick_wrap) begin
          if (int'(beat_q) == COUNTDOWN_BEATS - 1) begin
            state_d = S_PLAY;
            beat_d  = 8'd0;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      S_PLAY: begin
        if (lives_q == 2'd0) begin
          state_d = S_OVER;
          tick_d  = '0;
        end else begin
          tick_d = tick_wrap ? '0 : tick_q + TW'(1);
          // beat_cnt steps in the change_tick cycle, so it reads 1..SONG_BEATS
          // over the body of each beat.
          if (tick_q == '0) beat_d = beat_q + 8'd1;
          score_d = (score_sum > 18'h0FFFF) ? 16'hFFFF : score_sum[15:0];
          if (miss_cnt != 2'd0)      combo_d = 8'd0;
          else if (combo_sum > 9'd255) combo_d = 8'hFF;
          else                       combo_d = combo_sum[7:0];
          lives_d = (lives_q > miss_cnt) ? lives_q - miss_cnt : 2'd0;
          if (song_end) begin
            state_d = S_OVER;
            tick_d  = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    change_tick_d = (state_d == S_PLAY) && (tick_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      tick_q        <= '0;
      beat_q        <= 8'd0;
      score_q       <= 16'd0;
      combo_q       <= 8'd0;
      lives_q       <= 2'd0;
      change_tick_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      beat_q        <= beat_d;
      score_q       <= score_d;
      combo_q       <= combo_d;
      lives_q       <= lives_d;
      change_tick_q <= change_tick_d;
    end
  end

  assign change_tick = change_tick_q;
  assign target1     = tgt_all[0];
  assign target2     = tgt_all[1];
  assign target3     = tgt_all[2];
  assign score       = score_q;
  assign combo       = combo_q;
  assign lives       = lives_q;
  assign beat_cnt    = beat_q;
  assign state       = state_q;
  assign game_over   = (state_q == S_OVER);
endmodule

// File: tb/tb_step_scheduler.sv
// Bench for step_scheduler: directed game scenarios plus random play,
// checked every cycle against a phase-counting reference model.
module tb_step_scheduler;
  localparam int BT = 16, WT = 6, SB = 4, LV = 3, CB = 2;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [2:0]  n1, n2, n3, press;
  logic [1:0]  dir1, dir2, dir3;
  logic        change_tick, game_over;
  logic [2:0]  target1, target2, target3;
  logic [15:0] score;
  logic [7:0]  combo, beat_cnt;
  logic [1:0]  lives, state;

  int checks = 0, errors = 0;

  // reference model: cycles spent in current state, plus game counters
  int m_state, m_t, m_beat, m_score, m_combo, m_lives;
  int m_tgt[3];
  bit m_pend[3];

  step_scheduler #(.BEAT_TICKS(BT), .WINDOW_TICKS(WT), .SONG_BEATS(SB),
                   .LIVES(LV), .COUNTDOWN_BEATS(CB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n1(n1), .n2(n2), .n3(n3),
    .press(press), .dir1(dir1), .dir2(dir2), .dir3(dir3),
    .change_tick(change_tick), .target1(target1), .target2(target2),
    .target3(target3), .score(score), .combo(combo), .lives(lives),
    .beat_cnt(beat_cnt), .state(state), .game_over(game_over));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_t = 0; m_beat = 0; m_score = 0; m_combo = 0; m_lives = 0;
    for (int i = 0; i < 3; i++) begin m_tgt[i] = 4; m_pend[i] = 0; end
  endtask

  function automatic int exp_beat();
    if (m_state == 1) return m_t / BT;
    if (m_state == 2) return (m_t + BT - 1) / BT;
    return m_beat;
  endfunction

  // Advance the model across one clock edge using the inputs now driven.
  task automatic model_step();
    int nv[3], dv[3];
    int tick, hits, misses, gain;
    nv = '{int'(n1), int'(n2), int'(n3)};
    dv = '{int'(dir1), int'(dir2), int'(dir3)};
    case (m_state)
      0, 3: if (start) begin
        m_state = 1; m_t = 0; m_score = 0; m_combo = 0; m_lives = LV;
        for (int i = 0; i < 3; i++) begin m_tgt[i] = 4; m_pend[i] = 0; end
      end
      1: begin
        m_t++;
        if (m_t == CB * BT) begin m_state = 2; m_t = 0; end
      end
      default: begin
        tick = m_t % BT;
        m_beat = exp_beat();
        if (m_lives == 0) begin
          m_state = 3; m_t = 0;
          for (int i = 0; i < 3; i++) m_pend[i] = 0;
        end else begin
          hits = 0; misses = 0; gain = 0;
          for (int i = 0; i < 3; i++) begin
            if (tick == 1) begin
              m_tgt[i] = nv[i]; m_pend[i] = (nv[i] != 4);
            end else if (m_pend[i] && tick >= 2 && tick < WT + 2 && press[i]) begin
              if (dv[i] == m_tgt[i] % 4) begin hits++; gain += 10 + m_combo; end
              else misses++;
              m_pend[i] = 0;
            end else if (m_pend[i] && tick == WT + 2) begin
              misses++; m_pend[i] = 0;
            end
          end
          m_score = (m_score + gain > 65535) ? 65535 : m_score + gain;
          m_combo = (misses > 0) ? 0 : ((m_combo + hits > 255) ? 255 : m_combo + hits);
          m_lives = (m_lives > misses) ? m_lives - misses : 0;
          if (tick == BT - 1 && m_beat == SB) begin
            m_state = 3; m_t = 0;
            for (int i = 0; i < 3; i++) m_pend[i] = 0;
          end else m_t++;
        end
      end
    endcase
  endtask

  task automatic check_all();
    chk("state", 32'(state), 32'(m_state));
    chk("beat_cnt", 32'(beat_cnt), 32'(exp_beat()));
    chk("change_tick", 32'(change_tick), 32'(m_state == 2 && m_t % BT == 0));
    chk("score", 32'(score), 32'(m_score));
    chk("combo", 32'(combo), 32'(m_combo));
    chk("lives", 32'(lives), 32'(m_lives));
    chk("target1", 32'(target1), 32'(m_tgt[0]));
    chk("target2", 32'(target2), 32'(m_tgt[1]));
    chk("target3", 32'(target3), 32'(m_tgt[2]));
    chk("game_over", 32'(game_over), 32'(m_state == 3));
  endtask

  // mode 0 idle, 1 lane1 hit, 2 lane1 wrong dir, 3 lane1 unpressed, 4 random
  task automatic run(input int k, input int mode, input bit st_first);
    for (int j = 0; j < k; j++) begin
      @(negedge clk);
      start = st_first && (j == 0);
      press = 3'b000;
      if (mode == 4) begin
        n1 = 3'($urandom_range(0, 4)); n2 = 3'($urandom_range(0, 4));
        n3 = 3'($urandom_range(0, 4));
        dir1 = 2'($urandom); dir2 = 2'($urandom); dir3 = 2'($urandom);
        for (int i = 0; i < 3; i++) press[i] = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 15) == 0) start = 1'b1;
      end else begin
        n1 = (mode == 0) ? 3'($urandom_range(0, 4)) : 3'd2;
        n2 = 3'd4; n3 = 3'd4;
        dir1 = (mode == 2) ? 2'd1 : 2'd2; dir2 = 2'($urandom); dir3 = 2'($urandom);
        if ((mode == 1 || mode == 2) && m_state == 2 && m_t % BT == 4) press = 3'b001;
        // lanes with no arrow: pressing them must never matter
        if (mode != 0 && $urandom_range(0, 1) == 1) press[2:1] = 2'($urandom);
      end
      model_step();
      @(posedge clk); #1;
      check_all();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; press = '0;
    n1 = 3'd4; n2 = 3'd4; n3 = 3'd4; dir1 = '0; dir2 = '0; dir3 = '0;
    model_reset();
    #23 rst_n = 1'b1;
    #1 check_all();

    // 1: idle, start never issued
    run(100, 0, 0);
    chk("idle_state", 32'(state), 32'd0);

    // 2: countdown then play
    run(1, 1, 1);
    chk("count_state", 32'(state), 32'd1);
    run(32, 1, 0);
    chk("play_entry", 32'(state), 32'd2);
    chk("first_change_tick", 32'(change_tick), 32'd1);

    // 3: two hits
    run(16, 1, 0);
    chk("hit1_score", 32'(score), 32'd10);
    chk("hit1_combo", 32'(combo), 32'd1);
    run(16, 1, 0);
    chk("hit2_score", 32'(score), 32'd21);
    chk("hit2_combo", 32'(combo), 32'd2);

    // 4: wrong direction, then timeout; song ends after beat 4
    run(16, 2, 0);
    chk("wrong_combo", 32'(combo), 32'd0);
    chk("wrong_lives", 32'(lives), 32'd2);
    run(16, 3, 0);
    chk("timeout_lives", 32'(lives), 32'd1);
    chk("song_end_state", 32'(state), 32'd3);

    // 5: three misses end the game
    run(33, 2, 1);
    run(48, 2, 0);
    chk("dead_lives", 32'(lives), 32'd0);
    chk("dead_over", 32'(game_over), 32'd1);
    run(1, 0, 1);
    chk("restart_state", 32'(state), 32'd1);
    chk("restart_score", 32'(score), 32'd0);
    chk("restart_lives", 32'(lives), 32'd3);

    // 6: all hits across the song
    run(32, 1, 0);
    run(64, 1, 0);
    chk("full_song_state", 32'(state), 32'd3);
    chk("full_song_score", 32'(score), 32'd46);

    // asynchronous reset mid-PLAY
    run(1, 0, 1);
    run(40, 1, 0);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_change_tick", 32'(change_tick), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // random play
    repeat (8) begin
      run(1, 4, 1);
      run(150, 4, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
